// File: rtl/ps2_pad_pkg.sv
// Shared constants and the response-byte selector for the PS2 pad responder.
package ps2_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_IGNORE = 2'd2
  } state_e;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;
  localparam logic [7:0] ACK_BYTE  = 8'h5A;

  localparam logic [3:0] BYTE_HDR     = 4'd0;
  localparam logic [3:0] BYTE_ID      = 4'd1;
  localparam logic [3:0] BYTE_ACK     = 4'd2;
  localparam logic [3:0] BYTE_KEY_LO  = 4'd3;
  localparam logic [3:0] BYTE_KEY_HI  = 4'd4;
  localparam logic [3:0] BYTE_FILL    = 4'd5;
  localparam logic [3:0] BYTE_IDX_MAX = 4'd15;

  // Byte to start shifting out once byte index idx begins; buttons are active-low on the wire.
  function automatic logic [7:0] next_tx_byte(
    input logic [3:0]  idx,
    input logic        err,
    input logic [15:0] key,
    input logic [7:0]  pad_id,
    input logic [7:0]  fill
  );
    logic [7:0] v;
    v = fill;
    if (!err) begin
      case (idx)
        BYTE_ID:     v = pad_id;
        BYTE_ACK:    v = ACK_BYTE;
        BYTE_KEY_LO: v = ~key[7:0];
        BYTE_KEY_HI: v = ~key[15:8];
        default:     v = fill;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchroniser plus one history stage, producing single-cycle
// rise/fall pulses of the synchronised level.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_hist <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_hist;
  assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/ps2_pad_responder.sv
// SPI-side responder emulating a digital PS2 pad: answers the 0x01/0x42 poll
// with PAD_ID, 0x5A and two active-low button bytes, LSB first.
//
//   state     | meaning
//   ST_IDLE   | CS high, MISO parked high, waiting for CS fall
//   ST_ACTIVE | frame in progress, MOSI sampled on SCLK fall, MISO shifted on rise
//   ST_IGNORE | header byte was not 0x01, MISO high until CS rises
module ps2_pad_responder #(
  parameter logic [7:0] PAD_ID    = 8'h41,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        i_clk_50m,
  input  logic        i_rst,
  input  logic [15:0] i_key_state,
  input  logic        i_spi_cs,
  input  logic        i_spi_clk,
  input  logic        i_spi_mosi,
  output logic        o_spi_miso,
  output logic        o_frame_done,
  output logic        o_cmd_err,
  output logic [7:0]  o_last_cmd
);
  import ps2_pad_pkg::*;

  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic [7:0]  w_rx_byte;
  logic [3:0]  w_next_idx;

  logic        r_cs_meta;
  logic        r_cs_s;
  logic        r_mosi_meta;
  logic        r_mosi_s;

  state_e      r_state;
  logic [7:0]  r_tx_shift;
  logic [6:0]  r_rx_shift;
  logic [15:0] r_key_q;
  logic [2:0]  r_bit_cnt;
  logic [3:0]  r_byte_idx;
  logic        r_err;
  logic        r_frame_done;
  logic        r_cmd_err;
  logic [7:0]  r_last_cmd;

  sync_edge_det #(
    .RST_VAL (1'b1)
  ) u_sclk_sync (
    .i_clk   (i_clk_50m),
    .i_rst   (i_rst),
    .i_async (i_spi_clk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // CS and MOSI only need their level, so they skip the history stage.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      r_cs_meta   <= 1'b1;
      r_cs_s      <= 1'b1;
      r_mosi_meta <= 1'b0;
      r_mosi_s    <= 1'b0;
    end else begin
      r_cs_meta   <= i_spi_cs;
      r_cs_s      <= r_cs_meta;
      r_mosi_meta <= i_spi_mosi;
      r_mosi_s    <= r_mosi_meta;
    end
  end

  assign w_rx_byte  = {r_mosi_s, r_rx_shift};
  assign w_next_idx = (r_byte_idx == BYTE_IDX_MAX) ? r_byte_idx : r_byte_idx + 4'd1;

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_key_q      <= '0;
      r_bit_cnt    <= '0;
      r_byte_idx   <= '0;
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_last_cmd   <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_cmd_err    <= 1'b0;
      // CS high takes priority over any SCLK edge in the same cycle.
      if (r_cs_s) begin
        r_state      <= ST_IDLE;
        r_frame_done <= (r_state == ST_ACTIVE) && (r_byte_idx >= BYTE_FILL) && !r_err;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_ACTIVE;
            r_tx_shift <= FILL_BYTE;
            r_key_q    <= i_key_state;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_err      <= 1'b0;
          end
          ST_ACTIVE: begin
            if (w_sclk_fall) begin
              r_rx_shift <= w_rx_byte[7:1];
              if (r_bit_cnt == 3'd7) begin
                if (r_byte_idx == BYTE_HDR && w_rx_byte != CMD_START) begin
                  r_cmd_err <= 1'b1;
                  r_state   <= ST_IGNORE;
                end else if (r_byte_idx == BYTE_ID) begin
                  r_last_cmd <= w_rx_byte;
                  if (w_rx_byte != CMD_POLL) begin
                    r_cmd_err <= 1'b1;
                    r_err     <= 1'b1;
                  end
                end
              end
            end else if (w_sclk_rise) begin
              if (r_bit_cnt != 3'd7) begin
                r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
              end else begin
                r_bit_cnt  <= '0;
                r_byte_idx <= w_next_idx;
                r_tx_shift <= next_tx_byte(w_next_idx, r_err, r_key_q, PAD_ID, FILL_BYTE);
              end
            end
          end
          default: begin
            r_state <= ST_IGNORE;
          end
        endcase
      end
    end
  end

  assign o_spi_miso   = (r_state == ST_ACTIVE) ? r_tx_shift[0] : 1'b1;
  assign o_frame_done = r_frame_done;
  assign o_cmd_err    = r_cmd_err;
  assign o_last_cmd   = r_last_cmd;

endmodule

// File: tb/tb_ps2_pad_responder.sv
// Bench for ps2_pad_responder: acts as a PS2 poll master and compares every
// received byte and status pulse against a byte-level model of the pad.
module tb_ps2_pad_responder;

  localparam logic [7:0] PAD_ID = 8'h41;
  localparam logic [7:0] FILL   = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_state;
  logic        spi_cs;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        frame_done;
  logic        cmd_err;
  logic [7:0]  last_cmd;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_done = 0;
  int          n_err = 0;
  logic [7:0]  exp_last = 8'h00;
  logic [7:0]  f_tx [9];

  always #10 clk = ~clk;

  ps2_pad_responder #(
    .PAD_ID    (PAD_ID),
    .FILL_BYTE (FILL)
  ) dut (
    .i_clk_50m    (clk),
    .i_rst        (rst),
    .i_key_state  (key_state),
    .i_spi_cs     (spi_cs),
    .i_spi_clk    (spi_clk),
    .i_spi_mosi   (spi_mosi),
    .o_spi_miso   (spi_miso),
    .o_frame_done (frame_done),
    .o_cmd_err    (cmd_err),
    .o_last_cmd   (last_cmd)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) n_done++;
    if (cmd_err === 1'b1) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // What a real digital pad returns in byte i of a poll, given the first two command bytes.
  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] b0,
                                          input logic [7:0] b1, input logic [15:0] k);
    if (i == 0 || b0 != 8'h01) return FILL;
    if (i == 1) return PAD_ID;
    if (b1 != 8'h42) return FILL;
    case (i)
      2:       return 8'h5A;
      3:       return ~k[7:0];
      4:       return ~k[15:8];
      default: return FILL;
    endcase
  endfunction

  task automatic send_bits(input logic [7:0] d, input int nb, input int half,
                           output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi_mosi = d[i];
      wait_cyc(half);
      r[i] = spi_miso;
      spi_clk = 1'b0;
      wait_cyc(half);
      spi_clk = 1'b1;
    end
  endtask

  task automatic run_frame(input int nfull, input int npart, input int half,
                           input logic [15:0] key0, input int chg_at, input logic [15:0] key1);
    int         err0;
    int         done0;
    int         nb;
    logic [7:0] r;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       e_err;
    logic       e_done;
    err0  = n_err;
    done0 = n_done;
    b0 = f_tx[0];
    b1 = f_tx[1];
    nb = nfull + ((npart > 0) ? 1 : 0);
    key_state = key0;
    wait_cyc(1);
    spi_cs = 1'b0;
    wait_cyc(half + 4);
    for (int b = 0; b < nb; b++) begin
      if (b == chg_at) key_state = key1;
      send_bits(f_tx[b], (b < nfull) ? 8 : npart, half, r);
      if (b < nfull) begin
        chk($sformatf("miso_byte%0d", b), 32'(r), 32'(exp_byte(b, b0, b1, key0)));
        if (b == 0) chk("cmd_err_byte0", 32'(n_err - err0), 32'(b0 != 8'h01));
        if (b == 1) chk("cmd_err_byte1", 32'(n_err - err0), 32'((b0 != 8'h01) || (b1 != 8'h42)));
      end
    end
    wait_cyc(half);
    spi_cs = 1'b1;
    wait_cyc(8);
    e_err  = (nfull >= 1 && b0 != 8'h01) || (nfull >= 2 && b0 == 8'h01 && b1 != 8'h42);
    e_done = (nfull >= 5) && (b0 == 8'h01) && (b1 == 8'h42);
    if (nfull >= 2 && b0 == 8'h01) exp_last = b1;
    chk("miso_idle", 32'(spi_miso), 32'(1'b1));
    chk("last_cmd", 32'(last_cmd), 32'(exp_last));
    chk("frame_done", 32'(n_done - done0), 32'(e_done));
    chk("cmd_err_total", 32'(n_err - err0), 32'(e_err));
  endtask

  task automatic set_poll(input logic [7:0] b1);
    for (int i = 0; i < 9; i++) f_tx[i] = 8'($urandom);
    f_tx[0] = 8'h01;
    f_tx[1] = b1;
  endtask

  initial begin
    int         nfull;
    int         npart;
    int         err0;
    int         done0;
    logic [7:0] r;
    rst = 1'b1;
    spi_cs = 1'b1;
    spi_clk = 1'b1;
    spi_mosi = 1'b0;
    key_state = 16'h0000;
    wait_cyc(4);
    chk("rst_miso", 32'(spi_miso), 32'(1'b1));
    chk("rst_frame_done", 32'(frame_done), 32'(1'b0));
    chk("rst_cmd_err", 32'(cmd_err), 32'(1'b0));
    chk("rst_last_cmd", 32'(last_cmd), 32'(8'h00));
    rst = 1'b0;
    wait_cyc(4);

    // Nominal poll at a 600-cycle SCLK period
    for (int i = 0; i < 9; i++) f_tx[i] = 8'h00;
    f_tx[0] = 8'h01;
    f_tx[1] = 8'h42;
    run_frame(9, 0, 300, 16'h0011, -1, 16'h0000);

    // Bad header byte
    set_poll(8'h42);
    f_tx[0] = 8'h81;
    run_frame(9, 0, 6, 16'h1234, -1, 16'h0000);

    // Bad command byte
    set_poll(8'h43);
    run_frame(9, 0, 7, 16'h00F0, -1, 16'h0000);

    // Key snapshot held while key_state changes during byte 2
    set_poll(8'h42);
    run_frame(5, 0, 5, 16'h8000, 2, 16'hFFFF);

    // Abort after 3 bits of byte 3, then a clean frame
    set_poll(8'h42);
    run_frame(3, 3, 6, 16'h0F0F, -1, 16'h0000);
    set_poll(8'h42);
    run_frame(6, 0, 6, 16'hA55A, -1, 16'h0000);

    // Reset pulse in the middle of byte 2
    set_poll(8'h42);
    err0  = n_err;
    done0 = n_done;
    key_state = 16'h3C3C;
    wait_cyc(1);
    spi_cs = 1'b0;
    wait_cyc(10);
    send_bits(f_tx[0], 8, 6, r);
    send_bits(f_tx[1], 8, 6, r);
    send_bits(f_tx[2], 3, 6, r);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("rst_mid_miso", 32'(spi_miso), 32'(1'b1));
    spi_cs = 1'b1;
    wait_cyc(8);
    exp_last = 8'h00;
    chk("rst_mid_last_cmd", 32'(last_cmd), 32'(exp_last));
    chk("rst_mid_frame_done", 32'(n_done - done0), 32'd0);
    chk("rst_mid_cmd_err", 32'(n_err - err0), 32'd0);
    set_poll(8'h42);
    run_frame(7, 0, 5, 16'h0001, -1, 16'h0000);

    // Randomised frames
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 9; i++) f_tx[i] = 8'($urandom);
      if ($urandom_range(7, 0) != 0) f_tx[0] = 8'h01;
      if ($urandom_range(3, 0) != 0) f_tx[1] = 8'h42;
      nfull = $urandom_range(9, 1);
      npart = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
      if (nfull == 9) npart = 0;
      run_frame(nfull, npart, $urandom_range(10, 5), 16'($urandom),
                $urandom_range(9, 0), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
